tlb_walker: RTL and testbench

Hardware page-table walker on the miss side of the first-level `TLB`. It accepts a translation miss (va, pcid) and walks a radix page table in memory through a valid/ready read port. On success it pulses `insert` with the translated `pa`, which the TLB writes into its PLRU victim way. On an invalid entry it pulses `fault`.

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_walker_if.sv | 27 ++
 rtl/tlb_pte_decode.sv | 40 ++++
 rtl/tlb_walker.sv | 164 ++++++++++++++++
 tb/tb_tlb_walker.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the page-table walker: state encoding, PTE layout, walk geometry.
// Pure declarations, no logic.
package tlb_pkg;

   localparam int TLB_SADDR  = 64;
   localparam int TLB_SPAGE  = 12;
   localparam int TLB_SPCID  = 12;
   localparam int TLB_LEVELS = 4;
   localparam int TLB_SIDX   = 9;

   localparam int PTE_V       = 0;
   localparam int PTE_L       = 1;
   localparam int PTE_PPN_LSB = TLB_SPAGE;
   localparam int PTE_BYTES   = 8;
   localparam int PTE_SHIFT   = $clog2(PTE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_FAULT,
      S_DRAIN
   } walk_state_t;

   typedef enum logic [1:0] {
      PTE_DESCEND,
      PTE_LEAF,
      PTE_BAD
   } pte_class_t;

endpackage

// File: rtl/tlb_walker_if.sv
// PTE read port between the walker (master) and memory (slave): valid/ready request, unthrottled response.
// One outstanding request at a time; the request address is held while valid is up and ready is low.
interface tlb_walker_if #(
   parameter int SADDR = 64
) ();
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic [SADDR-1:0] mem_req_addr;
   logic             mem_resp_valid;
   logic [63:0]      mem_resp_data;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_data
   );
endinterface

// File: rtl/tlb_pte_decode.sv
// Combinational PTE decode: V/L/PPN extraction and classification into descend / leaf / fault.
// TLB_WALKER_SUPERPAGE_EN: a leaf above level 0 is a superpage leaf instead of a fault.
module tlb_pte_decode
   import tlb_pkg::*;
#(
   parameter int SADDR = TLB_SADDR,
   parameter int SPAGE = TLB_SPAGE
) (
   input  logic [63:0]            pte,
   input  logic                   lvl_zero,
   output logic [SADDR-SPAGE-1:0] ppn,
   output pte_class_t             cls
);
   logic v;
   logic l;
   logic unused_bits;

   assign v           = pte[PTE_V];
   assign l           = pte[PTE_L];
   assign ppn         = pte[SADDR-1:SPAGE];
   assign unused_bits = ^pte[SPAGE-1:PTE_L+1];

   always_comb begin
      cls = PTE_BAD;
      if (v) begin
         if (!l) begin
            // A pointer at the last level has nowhere left to go.
            cls = lvl_zero ? PTE_BAD : PTE_DESCEND;
         end else if (lvl_zero) begin
            cls = PTE_LEAF;
         end else begin
`ifdef TLB_WALKER_SUPERPAGE_EN
            cls = PTE_LEAF;
`else
            cls = PTE_BAD;
`endif
         end
      end
   end
endmodule

// File: rtl/tlb_walker.sv
// Radix page-table walker on the TLB miss path; one PTE read per level, insert/fault pulse 1 cycle after last response.
// Request stalls hold address stable; shutdown aborts (draining an in-flight response); superpages via TLB_WALKER_SUPERPAGE_EN.
module tlb_walker
   import tlb_pkg::*;
#(
   parameter int SADDR  = TLB_SADDR,
   parameter int SPAGE  = TLB_SPAGE,
   parameter int SPCID  = TLB_SPCID,
   parameter int LEVELS = TLB_LEVELS,
   parameter int SIDX   = TLB_SIDX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miss,
   input  logic [SADDR-1:0] va,
   input  logic [SPCID-1:0] pcid,
   input  logic [SADDR-1:0] ptbr,
   input  logic             shutdown,
   tlb_walker_if.master     mem,
   output logic             insert,
   output logic [SADDR-1:0] pa,
   output logic [SPCID-1:0] pcid_out,
   output logic             fault,
   output logic             busy
);
   localparam int LVLW  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int SBASE = SADDR - SPAGE;

   walk_state_t      state_q, state_d;
   logic [LVLW-1:0]  lvl_q, lvl_d;
   logic [SBASE-1:0] base_q, base_d;
   logic [SADDR-1:0] va_q, va_d;
   logic [SPCID-1:0] pcid_q, pcid_d;
   logic [SADDR-1:0] req_addr_d;
   logic [SADDR-1:0] pa_d;
   logic [SPCID-1:0] pcid_out_d;
   logic [SBASE-1:0] ppn;
   pte_class_t       cls;
   logic             unused_ptbr;

   assign unused_ptbr = ^ptbr[SPAGE-1:0];

   function automatic logic [SADDR-1:0] pte_addr(input logic [SBASE-1:0] base,
                                                 input logic [SADDR-1:0] vaddr,
                                                 input logic [LVLW-1:0]  l);
      logic [SADDR-1:0] shifted;
      shifted = vaddr >> (SPAGE + SIDX * int'(l));
      return {base, {SPAGE{1'b0}}} + (SADDR'(shifted[SIDX-1:0]) << PTE_SHIFT);
   endfunction

   // At level 0 the mask covers just the page offset, so one formula serves pages and superpages.
   function automatic logic [SADDR-1:0] leaf_pa(input logic [SBASE-1:0] frame,
                                                input logic [SADDR-1:0] vaddr,
                                                input logic [LVLW-1:0]  l);
      logic [SADDR-1:0] mask;
      mask = (SADDR'(1) << (SPAGE + SIDX * int'(l))) - SADDR'(1);
      return ({frame, {SPAGE{1'b0}}} & ~mask) | (vaddr & mask);
   endfunction

   tlb_pte_decode #(
      .SADDR (SADDR),
      .SPAGE (SPAGE)
   ) u_decode (
      .pte      (mem.mem_resp_data),
      .lvl_zero (lvl_q == '0),
      .ppn      (ppn),
      .cls      (cls)
   );

   always_comb begin
      state_d    = state_q;
      lvl_d      = lvl_q;
      base_d     = base_q;
      va_d       = va_q;
      pcid_d     = pcid_q;
      pa_d       = pa;
      pcid_out_d = pcid_out;
      req_addr_d = mem.mem_req_addr;

      case (state_q)
         S_IDLE: begin
            if (miss) begin
               va_d    = va;
               pcid_d  = pcid;
               base_d  = ptbr[SADDR-1:SPAGE];
               lvl_d   = LVLW'(LEVELS - 1);
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem.mem_req_ready) begin
               state_d = shutdown ? S_DRAIN : S_WAIT;
            end else if (shutdown) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (shutdown) begin
               // A same-cycle response is already consumed, so no drain is needed.
               state_d = mem.mem_resp_valid ? S_IDLE : S_DRAIN;
            end else if (mem.mem_resp_valid) begin
               case (cls)
                  PTE_DESCEND: begin
                     lvl_d   = lvl_q - LVLW'(1);
                     base_d  = ppn;
                     state_d = S_REQ;
                  end
                  PTE_LEAF: begin
                     pa_d       = leaf_pa(ppn, va_q, lvl_q);
                     pcid_out_d = pcid_q;
                     state_d    = S_DONE;
                  end
                  default: begin
                     pa_d    = '0;
                     state_d = S_FAULT;
                  end
               endcase
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         S_DRAIN: begin
            if (mem.mem_resp_valid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_REQ) begin
         req_addr_d = pte_addr(base_d, va_d, lvl_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= S_IDLE;
         lvl_q             <= '0;
         base_q            <= '0;
         va_q              <= '0;
         pcid_q            <= '0;
         mem.mem_req_valid <= 1'b0;
         mem.mem_req_addr  <= '0;
         insert            <= 1'b0;
         fault             <= 1'b0;
         pa                <= '0;
         pcid_out          <= '0;
         busy              <= 1'b0;
      end else begin
         state_q           <= state_d;
         lvl_q             <= lvl_d;
         base_q            <= base_d;
         va_q              <= va_d;
         pcid_q            <= pcid_d;
         mem.mem_req_valid <= (state_d == S_REQ);
         mem.mem_req_addr  <= req_addr_d;
         insert            <= (state_d == S_DONE);
         fault             <= (state_d == S_FAULT);
         pa                <= pa_d;
         pcid_out          <= pcid_out_d;
         busy              <= (state_d != S_IDLE);
      end
   end
endmodule

// File: tb/tb_tlb_walker.sv
// Directed bench for tlb_walker: a cycle-stepped memory model serves PTEs, scenario tasks check results inline.
module tb_tlb_walker;
   import tlb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        miss;
   logic        shutdown;
   logic [63:0] va;
   logic [63:0] ptbr;
   logic [11:0] pcid;
   logic        insert;
   logic        fault;
   logic        busy;
   logic [63:0] pa;
   logic [11:0] pcid_out;

   tlb_walker_if #(.SADDR(64)) mem_if ();

   tlb_walker dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .miss     (miss),
      .va       (va),
      .pcid     (pcid),
      .ptbr     (ptbr),
      .shutdown (shutdown),
      .mem      (mem_if),
      .insert   (insert),
      .pa       (pa),
      .pcid_out (pcid_out),
      .fault    (fault),
      .busy     (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] pte_a, pte_b, pte_c, pte_d;

   int          n_req, n_ins, n_flt, ins_cyc, resp_cyc, fall_cyc, stall_bad;
   bit          timed_out;
   logic [63:0] req_log [8];
   logic [63:0] pa_ins, pa_flt, stall_addr0;
   logic [11:0] pcid_ins;

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      if (a == 64'h1000) return pte_a;
      if (a == 64'h2000) return pte_b;
      if (a == 64'h3010) return pte_c;
      if (a == 64'h4018) return pte_d;
      return 64'h0;
   endfunction

   task automatic set_good_table();
      pte_a = 64'h2001;
      pte_b = 64'h3001;
      pte_c = 64'h4001;
      pte_d = 64'h88003;
   endtask

   // Issues one miss and plays memory until busy falls. Called and returns just after a negedge.
   task automatic serve(input int stall, input int shut_req, input bit spam, input int max_cyc);
      int          pend       = 0;
      int          stall_left = stall;
      bit          started    = 0;
      bit          shut_pend  = 0;
      logic [63:0] rd_addr    = 64'h0;
      n_req = 0; n_ins = 0; n_flt = 0; ins_cyc = -1; resp_cyc = -1; fall_cyc = -1;
      stall_bad = 0; timed_out = 1; stall_addr0 = 64'h0;
      miss = 1'b1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         miss = 1'b0;
         shutdown = 1'b0;
         mem_if.mem_resp_valid = 1'b0;
         if (insert) begin n_ins++; ins_cyc = c; pa_ins = pa; pcid_ins = pcid_out; end
         if (fault) begin n_flt++; pa_flt = pa; end
         if (busy) started = 1;
         else if (started) begin fall_cyc = c; timed_out = 0; break; end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_if.mem_resp_valid = 1'b1;
               mem_if.mem_resp_data  = mem_rd(rd_addr);
               resp_cyc = c;
            end
         end
         if (shut_pend) begin shutdown = 1'b1; shut_pend = 0; end
         mem_if.mem_req_ready = 1'b0;
         if (mem_if.mem_req_valid) begin
            if (stall_left > 0) begin
               if (stall_left == stall) stall_addr0 = mem_if.mem_req_addr;
               else if (mem_if.mem_req_addr !== stall_addr0) stall_bad++;
               stall_left--;
            end else begin
               mem_if.mem_req_ready = 1'b1;
               if (n_req < 8) req_log[n_req] = mem_if.mem_req_addr;
               rd_addr   = mem_if.mem_req_addr;
               pend      = (n_req == shut_req) ? 3 : 1;
               shut_pend = (n_req == shut_req);
               n_req++;
            end
         end else if (stall_left > 0 && stall_left < stall) begin
            stall_bad++;
         end
         if (spam && busy) begin miss = 1'b1; va = 64'h7fff_f000; end
      end
      miss = 1'b0;
      shutdown = 1'b0;
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_req_ready  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; miss = 1'b0; shutdown = 1'b0;
      va = 64'h403123; ptbr = 64'h1000; pcid = 12'h5a5;
      mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_data = 64'h0;
      set_good_table();
      repeat (3) @(negedge clk);
      n_checks++; if (mem_if.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", mem_if.mem_req_valid); end
      n_checks++; if (mem_if.mem_req_addr !== 64'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h expected 0", mem_if.mem_req_addr); end
      n_checks++; if (insert !== 1'b0) begin n_fail++; $display("FAIL rst_insert: got %b expected 0", insert); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", fault); end
      n_checks++; if (pa !== 64'h0) begin n_fail++; $display("FAIL rst_pa: got %h expected 0", pa); end
      n_checks++; if (pcid_out !== 12'h0) begin n_fail++; $display("FAIL rst_pcid_out: got %h expected 0", pcid_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_4level_hit();
      set_good_table();
      serve(0, -1, 0, 60);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL hit_timeout: got %b expected 0", timed_out); end
      n_checks++; if (n_req !== 4) begin n_fail++; $display("FAIL hit_nreq: got %0d expected 4", n_req); end
      n_checks++; if (req_log[0] !== 64'h1000) begin n_fail++; $display("FAIL hit_addr0: got %h expected 1000", req_log[0]); end
      n_checks++; if (req_log[1] !== 64'h2000) begin n_fail++; $display("FAIL hit_addr1: got %h expected 2000", req_log[1]); end
      n_checks++; if (req_log[2] !== 64'h3010) begin n_fail++; $display("FAIL hit_addr2: got %h expected 3010", req_log[2]); end
      n_checks++; if (req_log[3] !== 64'h4018) begin n_fail++; $display("FAIL hit_addr3: got %h expected 4018", req_log[3]); end
      n_checks++; if (n_ins !== 1) begin n_fail++; $display("FAIL hit_ninsert: got %0d expected 1", n_ins); end
      n_checks++; if (n_flt !== 0) begin n_fail++; $display("FAIL hit_nfault: got %0d expected 0", n_flt); end
      n_checks++; if (pa_ins !== 64'h88123) begin n_fail++; $display("FAIL hit_pa: got %h expected 88123", pa_ins); end
      n_checks++; if (pcid_ins !== 12'h5a5) begin n_fail++; $display("FAIL hit_pcid: got %h expected 5a5", pcid_ins); end
      n_checks++; if (ins_cyc !== 9) begin n_fail++; $display("FAIL hit_latency: got %0d expected 9", ins_cyc); end
   endtask

   task automatic test_invalid();
      set_good_table();
      pte_c = 64'h0;
      serve(0, -1, 0, 60);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL inv_timeout: got %b expected 0", timed_out); end
      n_checks++; if (n_req !== 3) begin n_fail++; $display("FAIL inv_nreq: got %0d expected 3", n_req); end
      n_checks++; if (req_log[2] !== 64'h3010) begin n_fail++; $display("FAIL inv_addr2: got %h expected 3010", req_log[2]); end
      n_checks++; if (n_flt !== 1) begin n_fail++; $display("FAIL inv_nfault: got %0d expected 1", n_flt); end
      n_checks++; if (n_ins !== 0) begin n_fail++; $display("FAIL inv_ninsert: got %0d expected 0", n_ins); end
      n_checks++; if (pa_flt !== 64'h0) begin n_fail++; $display("FAIL inv_pa: got %h expected 0", pa_flt); end
   endtask

   task automatic test_superpage();
      set_good_table();
      pte_c = 64'h200003;
      serve(0, -1, 0, 60);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL sp_timeout: got %b expected 0", timed_out); end
      n_checks++; if (n_req !== 3) begin n_fail++; $display("FAIL sp_nreq: got %0d expected 3", n_req); end
`ifdef TLB_WALKER_SUPERPAGE_EN
      n_checks++; if (n_ins !== 1) begin n_fail++; $display("FAIL sp_ninsert: got %0d expected 1", n_ins); end
      n_checks++; if (pa_ins !== 64'h203123) begin n_fail++; $display("FAIL sp_pa: got %h expected 203123", pa_ins); end
`else
      n_checks++; if (n_flt !== 1) begin n_fail++; $display("FAIL sp_nfault: got %0d expected 1", n_flt); end
      n_checks++; if (n_ins !== 0) begin n_fail++; $display("FAIL sp_ninsert: got %0d expected 0", n_ins); end
`endif
   endtask

   task automatic test_backpressure();
      set_good_table();
      serve(5, -1, 0, 80);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
      n_checks++; if (stall_addr0 !== 64'h1000) begin n_fail++; $display("FAIL bp_stall_addr: got %h expected 1000", stall_addr0); end
      n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_bad); end
      n_checks++; if (n_req !== 4) begin n_fail++; $display("FAIL bp_nreq: got %0d expected 4", n_req); end
      n_checks++; if (pa_ins !== 64'h88123) begin n_fail++; $display("FAIL bp_pa: got %h expected 88123", pa_ins); end
      n_checks++; if (ins_cyc !== 14) begin n_fail++; $display("FAIL bp_latency: got %0d expected 14", ins_cyc); end
   endtask

   task automatic test_flush();
      set_good_table();
      serve(0, 2, 0, 60);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL fl_timeout: got %b expected 0", timed_out); end
      n_checks++; if (n_req !== 3) begin n_fail++; $display("FAIL fl_nreq: got %0d expected 3", n_req); end
      n_checks++; if (n_ins !== 0) begin n_fail++; $display("FAIL fl_ninsert: got %0d expected 0", n_ins); end
      n_checks++; if (n_flt !== 0) begin n_fail++; $display("FAIL fl_nfault: got %0d expected 0", n_flt); end
      n_checks++; if (resp_cyc !== 8) begin n_fail++; $display("FAIL fl_resp_cyc: got %0d expected 8", resp_cyc); end
      n_checks++; if (fall_cyc !== 9) begin n_fail++; $display("FAIL fl_busy_fall: got %0d expected 9", fall_cyc); end
      serve(0, -1, 0, 60);
      n_checks++; if (req_log[0] !== 64'h1000) begin n_fail++; $display("FAIL fl_restart_addr: got %h expected 1000", req_log[0]); end
      n_checks++; if (n_ins !== 1) begin n_fail++; $display("FAIL fl_restart_insert: got %0d expected 1", n_ins); end
      n_checks++; if (pa_ins !== 64'h88123) begin n_fail++; $display("FAIL fl_restart_pa: got %h expected 88123", pa_ins); end
   endtask

   task automatic test_reset_mid_walk();
      set_good_table();
      mem_if.mem_req_ready = 1'b0;
      miss = 1'b1;
      @(negedge clk);
      miss = 1'b0;
      n_checks++; if (mem_if.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rm_in_req: got %b expected 1", mem_if.mem_req_valid); end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_if.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_req_valid: got %b expected 0", mem_if.mem_req_valid); end
      n_checks++; if (mem_if.mem_req_addr !== 64'h0) begin n_fail++; $display("FAIL rm_req_addr: got %h expected 0", mem_if.mem_req_addr); end
      n_checks++; if (insert !== 1'b0) begin n_fail++; $display("FAIL rm_insert: got %b expected 0", insert); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rm_fault: got %b expected 0", fault); end
      n_checks++; if (pa !== 64'h0) begin n_fail++; $display("FAIL rm_pa: got %h expected 0", pa); end
      n_checks++; if (pcid_out !== 12'h0) begin n_fail++; $display("FAIL rm_pcid_out: got %h expected 0", pcid_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      serve(0, -1, 1, 60);
      va = 64'h403123;
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rm_timeout: got %b expected 0", timed_out); end
      n_checks++; if (n_req !== 4) begin n_fail++; $display("FAIL rm_spam_nreq: got %0d expected 4", n_req); end
      n_checks++; if (req_log[3] !== 64'h4018) begin n_fail++; $display("FAIL rm_spam_addr3: got %h expected 4018", req_log[3]); end
      n_checks++; if (n_ins !== 1) begin n_fail++; $display("FAIL rm_spam_insert: got %0d expected 1", n_ins); end
      n_checks++; if (pa_ins !== 64'h88123) begin n_fail++; $display("FAIL rm_spam_pa: got %h expected 88123", pa_ins); end
   endtask

   initial begin
      test_reset();
      test_4level_hit();
      test_invalid();
      test_superpage();
      test_backpressure();
      test_flush();
      test_reset_mid_walk();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
